// File: rtl/decode_stage.sv
// RV32I decode stage: field split, immediate generation, control decode and a
// busy-register scoreboard that holds fetch on RAW/WAW hazards until writeback.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write_en,
  output logic [2:0]      out_wb_sel,
  output logic            out_mem_req,
  output logic            out_mem_req_write,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYS      = 7'b1110011;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_MEM  = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_SYS  = 3'd4;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  logic [6:0]       opcode;
  logic [4:0]       rs1, rs2, rd;
  logic             dec_rs1_used, dec_rs2_used, dec_we, dec_mem, dec_mw, dec_ill;
  logic [2:0]       dec_wb;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [31:0]      busy_full;
  logic             rs1_pend, rs2_pend, rd_pend, hazard, accept, squash;

  assign opcode = in_inst[6:0];
  assign rd     = in_inst[11:7];
  assign rs1    = in_inst[19:15];
  assign rs2    = in_inst[24:20];

  // Opcode decode: source usage, immediate format and control
  always_comb begin
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_we       = 1'b0;
    dec_wb       = WB_NONE;
    dec_mem      = 1'b0;
    dec_mw       = MEM_REQ_READ;
    dec_ill      = 1'b0;
    imm32        = '0;
    case (opcode)
      OPC_OP: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_we       = 1'b1;
        dec_wb       = WB_ALU;
      end
      OPC_OP_IMM: begin
        dec_rs1_used = 1'b1;
        dec_we       = 1'b1;
        dec_wb       = WB_ALU;
        imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_we = 1'b1;
        dec_wb = WB_ALU;
        imm32  = {in_inst[31:12], 12'b0};
      end
      OPC_LOAD: begin
        dec_rs1_used = 1'b1;
        dec_we       = 1'b1;
        dec_wb       = WB_MEM;
        dec_mem      = 1'b1;
        imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_STORE: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_mem      = 1'b1;
        dec_mw       = MEM_REQ_WRITE;
        imm32        = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BRANCH: begin
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        imm32        = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec_we = 1'b1;
        dec_wb = WB_PC4;
        imm32  = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec_rs1_used = 1'b1;
        dec_we       = 1'b1;
        dec_wb       = WB_PC4;
        imm32        = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_SYS: begin
        dec_we = 1'b1;
        dec_wb = WB_SYS;
        imm32  = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_MISC_MEM: ;
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_imm = XLEN'($signed(imm32));

  // A register is pending if busy and not being retired this very cycle
  assign busy_full = 32'(busy);
  assign rs1_pend  = (rs1 != 5'd0) && busy_full[rs1] && !(wb_valid && wb_rd == rs1);
  assign rs2_pend  = (rs2 != 5'd0) && busy_full[rs2] && !(wb_valid && wb_rd == rs2);
  assign rd_pend   = (rd  != 5'd0) && busy_full[rd]  && !(wb_valid && wb_rd == rd);
  assign hazard    = (dec_rs1_used && rs1_pend) || (dec_rs2_used && rs2_pend) || (dec_we && rd_pend);

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign squash   = flush && out_valid && out_reg_write_en && (out_rd != 5'd0);

  // Scoreboard next state; a set in the same cycle overrides any clear
  always_comb begin
    busy_nxt = busy;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (wb_valid && wb_rd == 5'(i)) busy_nxt[i] = 1'b0;
      if (squash && out_rd == 5'(i)) busy_nxt[i] = 1'b0;
      if (accept && dec_we && rd == 5'(i) && i != 0) busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid         <= 1'b0;
      out_pc            <= '0;
      out_rs1           <= '0;
      out_rs2           <= '0;
      out_rd            <= '0;
      out_opcode        <= '0;
      out_funct3        <= '0;
      out_funct7        <= '0;
      out_imm           <= '0;
      out_reg_write_en  <= 1'b0;
      out_wb_sel        <= WB_NONE;
      out_mem_req       <= 1'b0;
      out_mem_req_write <= 1'b0;
      out_illegal       <= 1'b0;
    end else if (accept) begin
      out_valid         <= 1'b1;
      out_pc            <= in_pc;
      out_rs1           <= rs1;
      out_rs2           <= rs2;
      out_rd            <= rd;
      out_opcode        <= opcode;
      out_funct3        <= in_inst[14:12];
      out_funct7        <= in_inst[31:25];
      out_imm           <= dec_imm;
      out_reg_write_en  <= dec_we;
      out_wb_sel        <= dec_wb;
      out_mem_req       <= dec_mem;
      out_mem_req_write <= dec_mw;
      out_illegal       <= dec_ill;
    end else if (out_ready || flush) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: per-format decode vectors plus hazard,
// stall, flush and reset-mid-stall sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd, wb_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3, out_wb_sel;
  logic        out_reg_write_en, out_mem_req, out_mem_req_write, out_illegal;
  logic        wb_valid, flush;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_reg_write_en(out_reg_write_en), .out_wb_sel(out_wb_sel),
    .out_mem_req(out_mem_req), .out_mem_req_write(out_mem_req_write),
    .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI5 = 32'hFFF08293;  // addi x5,x1,-1
  localparam logic [31:0] I_ADD6  = 32'h00528333;  // add  x6,x5,x5
  localparam logic [31:0] I_LUI10 = 32'h12345537;  // lui  x10,0x12345
  localparam logic [31:0] I_LW7   = 32'h0081A383;  // lw   x7,8(x3)
  localparam logic [31:0] I_NOP   = 32'h00000013;  // addi x0,x0,0

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        we;
    logic [2:0]  wb;
    logic        mem, mw, ill;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, 32'(in_ready), 32'd1);
  endtask

  task automatic clear_reg(input logic [4:0] r);
    in_valid = 1'b0;
    wb_valid = 1'b1;
    wb_rd    = r;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"addi", I_ADDI5,      32'h1000, 5'd5,  5'd1,  5'd31, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"sw",   32'hFE20AE23, 32'h1004, 5'd28, 5'd1,  5'd2,  3'd2, 32'hFFFFFFFC, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{"beq",  32'hFE208CE3, 32'h1008, 5'd25, 5'd1,  5'd2,  3'd0, 32'hFFFFFFF8, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"lui",  I_LUI10,      32'h100C, 5'd10, 5'd8,  5'd3,  3'd5, 32'h12345000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"jal",  32'h001000EF, 32'h1010, 5'd1,  5'd0,  5'd1,  3'd0, 32'h00000800, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"lw",   I_LW7,        32'h1014, 5'd7,  5'd3,  5'd8,  3'd2, 32'h00000008, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"ill",  32'h0000007F, 32'h1018, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"add",  I_ADD6,       32'h101C, 5'd6,  5'd5,  5'd5,  3'd0, 32'h00000000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{"auipc",32'hFFFFF197, 32'h1020, 5'd3,  5'd31, 5'd31, 3'd7, 32'hFFFFF000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{"jalr", 32'hFFC100E7, 32'h1024, 5'd1,  5'd2,  5'd28, 3'd0, 32'hFFFFFFFC, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;

    // Reset state
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", dut.busy, 32'd0);
    chk("rst_wb_sel", 32'(out_wb_sel), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Table-driven decode, one instruction at a time, scoreboard cleared after each
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc; out_ready = 1'b1;
      #1;
      wait_ready({vecs[i].name, "_ready"});
      tick();
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[i].name, "_pc"}, out_pc, vecs[i].pc);
      chk({vecs[i].name, "_rd"}, 32'(out_rd), 32'(vecs[i].rd));
      chk({vecs[i].name, "_rs1"}, 32'(out_rs1), 32'(vecs[i].rs1));
      chk({vecs[i].name, "_rs2"}, 32'(out_rs2), 32'(vecs[i].rs2));
      chk({vecs[i].name, "_opcode"}, 32'(out_opcode), 32'(vecs[i].inst[6:0]));
      chk({vecs[i].name, "_funct3"}, 32'(out_funct3), 32'(vecs[i].f3));
      chk({vecs[i].name, "_funct7"}, 32'(out_funct7), 32'(vecs[i].inst[31:25]));
      chk({vecs[i].name, "_imm"}, out_imm, vecs[i].imm);
      chk({vecs[i].name, "_we"}, 32'(out_reg_write_en), 32'(vecs[i].we));
      chk({vecs[i].name, "_wb_sel"}, 32'(out_wb_sel), 32'(vecs[i].wb));
      chk({vecs[i].name, "_mem"}, 32'(out_mem_req), 32'(vecs[i].mem));
      chk({vecs[i].name, "_mem_wr"}, 32'(out_mem_req_write), 32'(vecs[i].mw));
      chk({vecs[i].name, "_ill"}, 32'(out_illegal), 32'(vecs[i].ill));
      chk({vecs[i].name, "_busy"}, 32'(dut.busy[vecs[i].rd]),
          32'(vecs[i].we && vecs[i].rd != 5'd0));
      clear_reg(vecs[i].rd);
    end
    chk("busy_clean", dut.busy, 32'd0);

    // RAW hazard on x5 released by the matching writeback
    in_valid = 1'b1; in_inst = I_ADDI5; in_pc = 32'h100;
    #1;
    wait_ready("raw_addi_ready");
    tick();
    chk("raw_busy5_set", 32'(dut.busy[5]), 32'd1);
    in_inst = I_ADD6; in_pc = 32'h104;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("raw_stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    chk("raw_wb_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("raw_add_valid", 32'(out_valid), 32'd1);
    chk("raw_add_rd", 32'(out_rd), 32'd6);
    chk("raw_add_pc", out_pc, 32'h104);
    chk("raw_busy5_clr", 32'(dut.busy[5]), 32'd0);
    chk("raw_busy6_set", 32'(dut.busy[6]), 32'd1);
    clear_reg(5'd6);

    // Output stall: held instruction stays put while execute is not ready
    in_valid = 1'b1; in_inst = I_ADDI5; in_pc = 32'h200; out_ready = 1'b1;
    #1;
    wait_ready("stall_addi_ready");
    tick();
    out_ready = 1'b0; in_inst = I_LUI10; in_pc = 32'h204;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_rd", 32'(out_rd), 32'd5);
      chk("stall_imm", out_imm, 32'hFFFFFFFF);
      chk("stall_pc", out_pc, 32'h200);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("stall_next_valid", 32'(out_valid), 32'd1);
    chk("stall_next_rd", 32'(out_rd), 32'd10);
    chk("stall_next_pc", out_pc, 32'h204);
    chk("stall_next_imm", out_imm, 32'h12345000);
    clear_reg(5'd5);
    clear_reg(5'd10);

    // Flush of a held LW together with a writeback of a different register
    in_valid = 1'b1; in_inst = I_LUI10; in_pc = 32'h300; out_ready = 1'b1;
    #1;
    wait_ready("flush_lui_ready");
    tick();
    in_inst = I_LW7; in_pc = 32'h304;
    #1;
    wait_ready("flush_lw_ready");
    tick();
    out_ready = 1'b0; in_inst = I_ADD6; in_pc = 32'h308;
    chk("flush_busy7_set", 32'(dut.busy[7]), 32'd1);
    chk("flush_busy10_set", 32'(dut.busy[10]), 32'd1);
    flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd10;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; wb_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy7_clr", 32'(dut.busy[7]), 32'd0);
    chk("flush_busy10_clr", 32'(dut.busy[10]), 32'd0);
    chk("flush_busy6_none", 32'(dut.busy[6]), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("post_flush_ready", 32'(in_ready), 32'd1);
    tick();
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_rd", 32'(out_rd), 32'd6);
    chk("post_flush_pc", out_pc, 32'h308);
    clear_reg(5'd6);

    // x0 never hazards; then reset while a LW is held
    in_valid = 1'b1; in_inst = I_NOP; in_pc = 32'h400; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("x0_ready", 32'(in_ready), 32'd1);
      tick();
    end
    chk("x0_busy", dut.busy, 32'd0);
    in_inst = I_LW7; in_pc = 32'h410;
    #1;
    wait_ready("rst_lw_ready");
    tick();
    out_ready = 1'b0; in_inst = I_ADD6; in_pc = 32'h414;
    tick();
    tick();
    chk("rst_held_rd", 32'(out_rd), 32'd7);
    chk("rst_held_busy7", 32'(dut.busy[7]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", dut.busy, 32'd0);
    chk("rst_mid_rd", 32'(out_rd), 32'd0);
    chk("rst_mid_imm", out_imm, 32'd0);
    chk("rst_mid_pc", out_pc, 32'd0);
    chk("rst_mid_wb_sel", 32'(out_wb_sel), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
